// File: rtl/mem_access_responder.sv
// Memory-stage load/store responder: latches one single-data-transfer request,
// runs an Avalon-MM access to data memory and returns load/writeback results.
module mem_access_responder #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_byte,
   input  logic        req_P,
   input  logic        req_U,
   input  logic        req_W,
   input  logic [31:0] req_base,
   input  logic [31:0] req_offset,
   input  logic [31:0] req_store_data,
   input  logic [3:0]  req_rn,
   input  logic [3:0]  req_rd,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   output logic [31:0] mem_writedata,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   input  logic        mem_readdatavalid,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_rd_en,
   output logic [3:0]  resp_rd,
   output logic [31:0] resp_rd_data,
   output logic        resp_wb_en,
   output logic [3:0]  resp_rn,
   output logic [31:0] resp_wb_data,
   output logic        resp_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_next;
   logic        load_q, byte_q, wb_en_q, err_q;
   logic [31:0] eff_q, wb_data_q, store_data_q, rd_data_q;
   logic [3:0]  rn_q, rd_q;
   logic [15:0] count_q;

   logic [31:0] off_addr, eff, load_result;
   logic [1:0]  lane;
   logic        accept, timed_out, abort, in_access, in_resp;
   logic [3:0]  be_sel;

   assign off_addr  = req_U ? (req_base + req_offset) : (req_base - req_offset);
   assign eff       = req_P ? off_addr : req_base;
   assign accept    = req_valid && req_ready;
   assign lane      = eff_q[1:0];
   assign timed_out = (count_q == TIMEOUT_LAST);
   assign in_access = (state == ACCESS);
   assign in_resp   = (state == RESP);

   // A timeout only aborts when the cycle would not otherwise have completed.
   assign abort = timed_out &&
                  ((in_access && mem_waitrequest) ||
                   ((state == RDATA) && !mem_readdatavalid));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = ACCESS;
         ACCESS: begin
            if (!mem_waitrequest) state_next = load_q ? RDATA : RESP;
            else if (abort)       state_next = RESP;
         end
         RDATA:   if (mem_readdatavalid || abort) state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Byte loads pick one lane; word loads rotate so the addressed byte lands in bits 7:0.
   always_comb begin
      load_result = mem_readdata;
      if (byte_q) begin
         case (lane)
            2'd0:    load_result = {24'h0, mem_readdata[7:0]};
            2'd1:    load_result = {24'h0, mem_readdata[15:8]};
            2'd2:    load_result = {24'h0, mem_readdata[23:16]};
            default: load_result = {24'h0, mem_readdata[31:24]};
         endcase
      end else begin
         case (lane)
            2'd1:    load_result = {mem_readdata[7:0],  mem_readdata[31:8]};
            2'd2:    load_result = {mem_readdata[15:0], mem_readdata[31:16]};
            2'd3:    load_result = {mem_readdata[23:0], mem_readdata[31:24]};
            default: load_result = mem_readdata;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         load_q       <= 1'b0;
         byte_q       <= 1'b0;
         wb_en_q      <= 1'b0;
         err_q        <= 1'b0;
         eff_q        <= '0;
         wb_data_q    <= '0;
         store_data_q <= '0;
         rd_data_q    <= '0;
         rn_q         <= '0;
         rd_q         <= '0;
         count_q      <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            load_q       <= req_load;
            byte_q       <= req_byte;
            wb_en_q      <= !req_P || req_W;
            eff_q        <= eff;
            wb_data_q    <= off_addr;
            store_data_q <= req_store_data;
            rn_q         <= req_rn;
            rd_q         <= req_rd;
            err_q        <= 1'b0;
            count_q      <= '0;
         end else if (in_access || (state == RDATA)) begin
            count_q <= count_q + 16'd1;
         end
         if (abort) err_q <= 1'b1;
         if ((state == RDATA) && mem_readdatavalid) rd_data_q <= load_result;
      end
   end

   assign be_sel = byte_q ? (4'b0001 << lane) : 4'hF;

   assign req_ready      = (state == IDLE);
   assign mem_read       = in_access && load_q;
   assign mem_write      = in_access && !load_q;
   assign mem_addr       = in_access ? {eff_q[31:2], 2'b00} : '0;
   assign mem_byteenable = in_access ? be_sel : '0;
   assign mem_writedata  = !in_access ? '0 : (byte_q ? {4{store_data_q[7:0]}} : store_data_q);

   assign resp_valid   = in_resp;
   assign resp_rd_en   = in_resp && load_q && !err_q;
   assign resp_wb_en   = in_resp && wb_en_q && !err_q;
   assign resp_rd      = in_resp ? rd_q : '0;
   assign resp_rn      = in_resp ? rn_q : '0;
   assign resp_rd_data = in_resp ? rd_data_q : '0;
   assign resp_wb_data = in_resp ? wb_data_q : '0;
   assign resp_err     = in_resp && err_q;

endmodule
